// File: rtl/icache_assoc_if.sv
// Bus bundle between the instruction cache, the datapath fetch port and the memory read port.
// The slave modport is the cache's view of the bus.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational lookup, round-robin replacement,
// multi-beat block fill from a wait-stated memory port.
module icache_assoc #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input logic            CLK,
  input logic            nRST,
  icache_assoc_if.slave  bus
);

  localparam int OFFB = $clog2(BLKWORDS);
  localparam int OFFW = (OFFB > 0) ? OFFB : 1;
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - OFFB - IDXW;
  localparam int PTRW = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]      state_r;
  logic            valid_r [SETS][WAYS];
  logic [TAGW-1:0] tag_r   [SETS][WAYS];
  logic [31:0]     data_r  [SETS][WAYS][BLKWORDS];
  logic [PTRW-1:0] ptr_r   [SETS];
  logic [31:0]     buf_r   [BLKWORDS];
  logic [TAGW-1:0] ftag_r;
  logic [IDXW-1:0] fidx_r;
  logic [OFFW-1:0] cnt_r;
  logic            iren_r;
  logic [31:0]     iaddr_r;

  logic [TAGW-1:0] tag_s;
  logic [IDXW-1:0] index_s;
  logic [OFFW-1:0] offset_s;
  logic            hit_any_s;
  logic [PTRW-1:0] hit_way_s;
  logic            lookup_en_s;
  logic            hit_s;
  logic            miss_s;
  logic [PTRW-1:0] victim_s;
  logic            evict_s;
  logic            last_s;

  assign tag_s   = bus.imemaddr[31 -: TAGW];
  assign index_s = bus.imemaddr[2 + OFFB +: IDXW];

  generate
    if (OFFB > 0) begin : g_off
      assign offset_s = bus.imemaddr[2 +: OFFW];
    end else begin : g_no_off
      assign offset_s = {OFFW{1'b0}};
    end
  endgenerate

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_any_s = 1'b0;
    hit_way_s = {PTRW{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (valid_r[index_s][w] && (tag_r[index_s][w] == tag_s)) begin
        hit_any_s = 1'b1;
        hit_way_s = PTRW'(w);
      end else begin
        hit_any_s = hit_any_s;
      end
    end
  end

  assign lookup_en_s  = bus.imemREN & ~bus.dmemREN & ~bus.dmemWEN & (state_r == IDLE);
  assign hit_s        = lookup_en_s & hit_any_s;
  assign miss_s       = lookup_en_s & ~hit_any_s & ~bus.flush;
  assign bus.ihit     = hit_s & ~bus.flush;
  assign bus.imemload = bus.ihit ? data_r[index_s][hit_way_s][offset_s] : 32'h0000_0000;
  assign bus.iREN     = iren_r;
  assign bus.iaddr    = iaddr_r;
  assign last_s       = (cnt_r == OFFW'(BLKWORDS - 1));

  // Victim selection: first invalid way wins, otherwise the round-robin pointer.
  always_comb begin
    victim_s = ptr_r[fidx_r];
    evict_s  = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      if (evict_s && !valid_r[fidx_r][w]) begin
        victim_s = PTRW'(w);
        evict_s  = 1'b0;
      end else begin
        victim_s = victim_s;
      end
    end
  end

  // Fill state machine, line storage and memory request registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      ftag_r  <= {TAGW{1'b0}};
      fidx_r  <= {IDXW{1'b0}};
      cnt_r   <= {OFFW{1'b0}};
      iren_r  <= 1'b0;
      iaddr_r <= 32'h0000_0000;
      for (int k = 0; k < BLKWORDS; k++) begin
        buf_r[k] <= 32'h0000_0000;
      end
      for (int s = 0; s < SETS; s++) begin
        ptr_r[s] <= {PTRW{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          tag_r[s][w]   <= {TAGW{1'b0}};
          for (int k = 0; k < BLKWORDS; k++) begin
            data_r[s][w][k] <= 32'h0000_0000;
          end
        end
      end
    end else if (bus.flush) begin
      // Flush beats everything, including a fill completing this same cycle.
      state_r <= IDLE;
      iren_r  <= 1'b0;
      iaddr_r <= 32'h0000_0000;
      for (int s = 0; s < SETS; s++) begin
        ptr_r[s] <= {PTRW{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
        end
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            state_r <= FILL;
            ftag_r  <= tag_s;
            fidx_r  <= index_s;
            cnt_r   <= {OFFW{1'b0}};
            iren_r  <= 1'b1;
            iaddr_r <= {tag_s, index_s, {(OFFB + 2){1'b0}}};
          end
        end
        FILL: begin
          if (!bus.iwait) begin
            if (last_s) begin
              for (int k = 0; k < BLKWORDS; k++) begin
                data_r[fidx_r][victim_s][k] <= (k == BLKWORDS - 1) ? bus.iload : buf_r[k];
              end
              valid_r[fidx_r][victim_s] <= 1'b1;
              tag_r[fidx_r][victim_s]   <= ftag_r;
              if (evict_s) begin
                ptr_r[fidx_r] <= (ptr_r[fidx_r] == PTRW'(WAYS - 1)) ? {PTRW{1'b0}}
                                                                    : ptr_r[fidx_r] + PTRW'(1);
              end
              state_r <= IDLE;
              iren_r  <= 1'b0;
              iaddr_r <= 32'h0000_0000;
            end else begin
              buf_r[cnt_r] <= bus.iload;
              cnt_r        <= cnt_r + OFFW'(1);
              iaddr_r      <= iaddr_r + 32'd4;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          iren_r  <= 1'b0;
          iaddr_r <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule
